// File: rtl/speck128_round_unit.sv
// speck128_round_unit
//   Single-stage SPECK128/128 datapath with two independent engines sharing
//   one FSM shape (IDLE -> ADD -> MIX -> DONE):
//     round engine : x' = (ROR(x,8) + y) ^ subkey ; y' = ROL(y,3) ^ x'
//     key schedule : l' = (ROR(l,8) + k) ^ round_ctr ; k' = ROL(k,3) ^ l'
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     ks_start, key, round_ctr key-schedule start and operands
//     out_key, ks_finished     next key state {k',l'} and sticky valid
//     ks_state                 key-schedule FSM state code
//     rd_start, subkey,        round start and operands ({x,y} block)
//     plaintext
//     ciphertext, rd_finished  round result {x',y'} and sticky valid
//     rd_state                 round FSM state code

// speck128_engine
//   Generic rotate-add-xor engine. Computes
//     first  = (ROR(a,8) + b) ^ c
//     second = ROL(b,3) ^ first
//   and presents result_o = {first, second}.
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     start_i           start request, accepted in IDLE or DONE
//     a_i, b_i, c_i     64-bit operands, latched on acceptance
//     result_o          {first, second}, held from DONE until next MIX
//     finished_o        sticky valid, cleared on next accepted start
//     state_o           FSM state code
module speck128_engine (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [63:0]  a_i,
  input  logic [63:0]  b_i,
  input  logic [63:0]  c_i,
  output logic [127:0] result_o,
  output logic         finished_o,
  output logic [3:0]   state_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_ADD  = 4'd1,
    S_MIX  = 4'd2,
    S_DONE = 4'd3
  } state_t;

  state_t        state_q;
  logic [63:0]   a_q, b_q, c_q;
  logic [63:0]   word_q;
  logic [127:0]  result_q;
  logic          finished_q;
  logic [63:0]   word_d;
  logic [63:0]   mix_d;

  always_comb begin
    word_d = ({a_q[7:0], a_q[63:8]} + b_q) ^ c_q;
    mix_d  = {b_q[60:0], b_q[63:61]} ^ word_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      word_q     <= '0;
      result_q   <= '0;
      finished_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            a_q        <= a_i;
            b_q        <= b_i;
            c_q        <= c_i;
            finished_q <= 1'b0;
            state_q    <= S_ADD;
          end
        end
        S_ADD: begin
          word_q  <= word_d;
          state_q <= S_MIX;
        end
        S_MIX: begin
          result_q   <= {word_q, mix_d};
          finished_q <= 1'b1;
          state_q    <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign finished_o = finished_q;
  assign state_o    = state_q;

endmodule

module speck128_round_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic         ks_start,
  input  logic [127:0] key,
  input  logic [63:0]  round_ctr,
  output logic [127:0] out_key,
  output logic         ks_finished,
  output logic [3:0]   ks_state,
  input  logic         rd_start,
  input  logic [63:0]  subkey,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic         rd_finished,
  output logic [3:0]   rd_state
);

  logic [127:0] ks_res;

  speck128_engine u_round (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (rd_start),
    .a_i        (plaintext[127:64]),
    .b_i        (plaintext[63:0]),
    .c_i        (subkey),
    .result_o   (ciphertext),
    .finished_o (rd_finished),
    .state_o    (rd_state)
  );

  // Key schedule maps onto the same engine with a=l, b=k, c=round_ctr;
  // the engine yields {l', k'}, so the halves are swapped to form {k', l'}.
  speck128_engine u_keysched (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (ks_start),
    .a_i        (key[63:0]),
    .b_i        (key[127:64]),
    .c_i        (round_ctr),
    .result_o   (ks_res),
    .finished_o (ks_finished),
    .state_o    (ks_state)
  );

  assign out_key = {ks_res[63:0], ks_res[127:64]};

endmodule

// File: tb/tb_speck128_round_unit.sv
module tb_speck128_round_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ks_start = 1'b0;
  logic [127:0] key = '0;
  logic [63:0]  round_ctr = '0;
  logic [127:0] out_key;
  logic         ks_finished;
  logic [3:0]   ks_state;
  logic         rd_start = 1'b0;
  logic [63:0]  subkey = '0;
  logic [127:0] plaintext = '0;
  logic [127:0] ciphertext;
  logic         rd_finished;
  logic [3:0]   rd_state;

  int total = 0;
  int bad   = 0;
  bit en    = 1'b0;

  always #5 clk = ~clk;

  speck128_round_unit dut (
    .clk         (clk),
    .rst         (rst),
    .ks_start    (ks_start),
    .key         (key),
    .round_ctr   (round_ctr),
    .out_key     (out_key),
    .ks_finished (ks_finished),
    .ks_state    (ks_state),
    .rd_start    (rd_start),
    .subkey      (subkey),
    .plaintext   (plaintext),
    .ciphertext  (ciphertext),
    .rd_finished (rd_finished),
    .rd_state    (rd_state)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int unsigned n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] spk_round(input logic [127:0] blk, input logic [63:0] k);
    logic [63:0] x, y;
    x = (ror64(blk[127:64], 8) + blk[63:0]) ^ k;
    y = rol64(blk[63:0], 3) ^ x;
    return {x, y};
  endfunction

  function automatic logic [127:0] spk_keystep(input logic [127:0] kl, input logic [63:0] i);
    logic [63:0] k, l;
    l = (ror64(kl[63:0], 8) + kl[127:64]) ^ i;
    k = rol64(kl[127:64], 3) ^ l;
    return {k, l};
  endfunction

  // ---------------- behavioural model ----------------
  // age = cycles since the last accepted start (0 = never started, saturates at 3).
  // The reported state is exactly that age; the result appears when age reaches 3.
  int           rd_age, ks_age;
  logic [127:0] rd_pend, rd_exp, ks_pend, ks_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_age = 0; rd_exp = '0; rd_pend = '0;
    end else if ((rd_age == 0 || rd_age == 3) && rd_start) begin
      rd_pend = spk_round(plaintext, subkey);
      rd_age  = 1;
    end else if (rd_age == 1 || rd_age == 2) begin
      rd_age = rd_age + 1;
      if (rd_age == 3) rd_exp = rd_pend;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_age = 0; ks_exp = '0; ks_pend = '0;
    end else if ((ks_age == 0 || ks_age == 3) && ks_start) begin
      ks_pend = spk_keystep(key, round_ctr);
      ks_age  = 1;
    end else if (ks_age == 1 || ks_age == 2) begin
      ks_age = ks_age + 1;
      if (ks_age == 3) ks_exp = ks_pend;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      chk("m_ciphertext", ciphertext, rd_exp);
      chk("m_rd_fin", {127'd0, rd_finished}, {127'd0, rd_age == 3});
      chk("m_rd_state", {124'd0, rd_state}, 128'(rd_age));
      chk("m_out_key", out_key, ks_exp);
      chk("m_ks_fin", {127'd0, ks_finished}, {127'd0, ks_age == 3});
      chk("m_ks_state", {124'd0, ks_state}, 128'(ks_age));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Raises the selected starts for one sampling edge; returns 1ns after it.
  task automatic pulse(input bit rd, input bit ks);
    @(posedge clk); #1;
    rd_start = rd; ks_start = ks;
    @(posedge clk); #1;
    rd_start = 1'b0; ks_start = 1'b0;
  endtask

  // Counts edges (starting from cyc0) until the chosen finished flag is seen.
  task automatic wait_fin(input bit sel_ks, input int cyc0, output int cyc);
    cyc = cyc0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      cyc++;
      if ((sel_ks ? ks_finished : rd_finished) === 1'b1) return;
    end
    total++; bad++;
    $display("FAIL wait_fin timeout sel_ks=%0d got cycles=%0d expected 3", sel_ks, cyc);
  endtask

  localparam logic [127:0] PT  = {64'h6c61766975716520, 64'h7469206564616d20};
  localparam logic [63:0]  SK0 = 64'h0706050403020100;
  localparam logic [127:0] KEY = {64'h0706050403020100, 64'h0f0e0d0c0b0a0908};
  localparam logic [127:0] CT1 = {64'h93d384dfced4df85, 64'h309a87f4eddfb686};
  localparam logic [127:0] KS1 = {64'h37253b31171d0309, 64'h0f1513110f0d0b09};
  localparam logic [127:0] CTF = {64'ha65d985179783265, 64'h7860fedf5c570d18};

  initial begin
    int cyc;
    logic [127:0] blk, k, held, p1;

    // reset
    #23 rst = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    chk("rst_ct", ciphertext, '0);
    chk("rst_key", out_key, '0);
    chk("rst_states", {120'd0, rd_state, ks_state}, '0);
    chk("rst_fin", {126'd0, rd_finished, ks_finished}, '0);

    // pin the model against published vectors
    chk("model_round", spk_round(PT, SK0), CT1);
    chk("model_ks", spk_keystep(KEY, 64'd0), KS1);

    // round vector
    plaintext = PT; subkey = SK0;
    pulse(1'b1, 1'b0);
    wait_fin(1'b0, 1, cyc);
    chk("rd_latency", 128'(cyc), 128'd3);
    chk("rd_vector", ciphertext, CT1);

    // key-schedule vector
    key = KEY; round_ctr = '0;
    pulse(1'b0, 1'b1);
    wait_fin(1'b1, 1, cyc);
    chk("ks_latency", 128'(cyc), 128'd3);
    chk("ks_vector", out_key, KS1);

    // start while busy: second request during ADD is ignored
    p1 = {$urandom, $urandom, $urandom, $urandom};
    plaintext = p1; subkey = 64'h0123456789abcdef;
    pulse(1'b1, 1'b0);
    plaintext = ~p1; rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    wait_fin(1'b0, 2, cyc);
    chk("busy_latency", 128'(cyc), 128'd3);
    chk("busy_result", ciphertext, spk_round(p1, 64'h0123456789abcdef));

    // hold in DONE, then restart
    held = ciphertext;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    chk("hold_ct", ciphertext, held);
    chk("hold_fin", {127'd0, rd_finished}, 128'd1);
    p1 = plaintext;
    pulse(1'b1, 1'b0);
    chk("restart_fin_clr", {127'd0, rd_finished}, '0);
    wait_fin(1'b0, 1, cyc);
    chk("restart_result", ciphertext, spk_round(p1, 64'h0123456789abcdef));

    // start held high across several cycles, both engines together
    @(posedge clk); #1;
    rd_start = 1'b1; ks_start = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
    end
    rd_start = 1'b0; ks_start = 1'b0;
    repeat (4) @(posedge clk);

    // asynchronous reset while in MIX
    pulse(1'b1, 1'b1);
    @(posedge clk); #1;
    chk("mix_state", {124'd0, rd_state}, 128'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst_ct", ciphertext, '0);
    chk("arst_key", out_key, '0);
    chk("arst_state", {120'd0, rd_state, ks_state}, '0);
    chk("arst_fin", {126'd0, rd_finished, ks_finished}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", {118'd0, rd_finished, ks_finished, rd_state, ks_state}, '0);

    // full 32-round cipher: round i uses k_i while the key schedule derives k_(i+1)
    blk = PT; k = KEY;
    for (int i = 0; i < 32; i++) begin
      plaintext = blk; subkey = k[127:64];
      key = k; round_ctr = 64'(i);
      pulse(1'b1, i < 31);
      wait_fin(1'b0, 1, cyc);
      blk = ciphertext;
      if (i < 31) k = out_key;
    end
    chk("full_cipher", blk, CTF);

    // randomized traffic, every cycle checked against the model
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      rd_start  = ($urandom_range(0, 2) == 0);
      ks_start  = ($urandom_range(0, 2) == 0);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      subkey    = {$urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      round_ctr = {$urandom, $urandom};
    end
    rd_start = 1'b0; ks_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
